// File: rtl/gps_pkg.sv
// rtl/gps_pkg.sv - shared constants, state types and hex helper for the GPS UART front end
package gps_pkg;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {C_IDLE, C_SUM, C_HI, C_LO} cks_state_t;

  // Returns {ok, nibble}; ok=0 for anything outside 0-9, A-F, a-f.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

endpackage

// File: rtl/gps_uart_rx_if.sv
// rtl/gps_uart_rx_if.sv - serial line in, byte strobe and sentence status out
interface gps_uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       sentence_done;
  logic       checksum_ok;

  modport master (output rx, input data, valid, frame_err, sentence_done, checksum_ok);
  modport slave  (input rx, output data, valid, frame_err, sentence_done, checksum_ok);
endinterface

// File: rtl/nmea_checksum.sv
// rtl/nmea_checksum.sv - NMEA '$...*HH' framing and XOR checksum tracker
module nmea_checksum
  import gps_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_stb,
  input  logic       i_abort,
  output logic       o_done,
  output logic       o_ok
);

  cks_state_t r_state;
  logic [7:0] r_sum;
  logic [3:0] r_hi;
  logic       r_bad;
  logic       r_done;
  logic       r_ok;
  logic [4:0] w_hex;

  assign w_hex  = hex_to_nibble(i_byte);
  assign o_done = r_done;
  assign o_ok   = r_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_IDLE;
      r_sum   <= 8'd0;
      r_hi    <= 4'd0;
      r_bad   <= 1'b0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_state <= C_IDLE;
      end else if (i_stb) begin
        // '$' always restarts a sentence, whatever state we are in.
        if (i_byte == ASCII_DOLLAR) begin
          r_sum   <= 8'd0;
          r_state <= C_SUM;
        end else begin
          case (r_state)
            C_IDLE: r_state <= C_IDLE;
            C_SUM: begin
              if (i_byte == ASCII_STAR) begin
                r_bad   <= 1'b0;
                r_state <= C_HI;
              end else if (i_byte == ASCII_CR) begin
                r_state <= C_IDLE;
              end else begin
                r_sum <= r_sum ^ i_byte;
              end
            end
            C_HI: begin
              r_hi    <= w_hex[3:0];
              r_bad   <= ~w_hex[4];
              r_state <= C_LO;
            end
            C_LO: begin
              r_done  <= 1'b1;
              r_ok    <= !r_bad && w_hex[4] && ({r_hi, w_hex[3:0]} == r_sum);
              r_state <= C_IDLE;
            end
            default: r_state <= C_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/gps_uart_rx.sv
// rtl/gps_uart_rx.sv - 8N1 UART receiver for the GPS module with NMEA checksum check
module gps_uart_rx
  import gps_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int VALID_TICKS = 8
) (
  input logic         clk,
  input logic         rst,
  gps_uart_rx_if.slave bus
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int VW  = $clog2(VALID_TICKS + 1);

  logic          r_sync1, r_sync2, r_rxs_d;
  logic [DW-1:0] r_div_cnt;
  rx_state_t     r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_s0, r_s1;
  logic [7:0]    r_data;
  logic          r_valid, r_valid_d, r_restart;
  logic [VW-1:0] r_vcnt;
  logic          r_frame_err;
  logic          w_tick, w_rxs, w_fall, w_maj, w_stb, w_done, w_ok;

  assign w_rxs  = r_sync2;
  assign w_fall = r_rxs_d & ~r_sync2;
  assign w_tick = (r_div_cnt == DW'(DIV - 1));
  assign w_maj  = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_stb  = r_valid & ~r_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rxs_d   <= 1'b1;
      r_div_cnt <= '0;
      r_valid_d <= 1'b0;
    end else begin
      r_sync1   <= bus.rx;
      r_sync2   <= r_sync1;
      r_rxs_d   <= r_sync2;
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_valid_d <= r_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_s0        <= 1'b1;
      r_s1        <= 1'b1;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_restart   <= 1'b0;
      r_vcnt      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_restart) begin
        r_restart <= 1'b0;
        r_valid   <= 1'b1;
        r_vcnt    <= '0;
      end else if (w_tick && r_valid) begin
        if (r_vcnt == VW'(VALID_TICKS - 1)) r_valid <= 1'b0;
        else r_vcnt <= r_vcnt + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state    <= START;
            r_tick_cnt <= '0;
          end
        end
        // Checked at mid-bit, but held to the bit end so DATA counts bit-aligned ticks.
        START: if (w_tick) begin
          if (r_tick_cnt == TW'(M - 1) && w_rxs) begin
            r_state <= IDLE;
          end else if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
            r_state    <= DATA;
            r_tick_cnt <= '0;
            r_bit_cnt  <= 3'd0;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        DATA: if (w_tick) begin
          if (r_tick_cnt == TW'(M - 2)) r_s0 <= w_rxs;
          if (r_tick_cnt == TW'(M - 1)) r_s1 <= w_rxs;
          if (r_tick_cnt == TW'(M))     r_shift <= {w_maj, r_shift[7:1]};
          if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
            r_tick_cnt <= '0;
            if (r_bit_cnt == 3'd7) r_state <= STOP;
            else r_bit_cnt <= r_bit_cnt + 1'b1;
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        STOP: if (w_tick) begin
          if (r_tick_cnt == TW'(M - 1)) begin
            r_state <= IDLE;
            if (w_rxs) begin
              r_data <= r_shift;
              // A byte landing while valid is high forces a one-clk gap so the rise is visible.
              if (r_valid) begin
                r_valid   <= 1'b0;
                r_restart <= 1'b1;
              end else begin
                r_valid <= 1'b1;
                r_vcnt  <= '0;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  nmea_checksum u_cks (
    .clk     (clk),
    .rst     (rst),
    .i_byte  (r_data),
    .i_stb   (w_stb),
    .i_abort (r_frame_err),
    .o_done  (w_done),
    .o_ok    (w_ok)
  );

  assign bus.data          = r_data;
  assign bus.valid         = r_valid;
  assign bus.frame_err     = r_frame_err;
  assign bus.sentence_done = w_done;
  assign bus.checksum_ok   = w_ok;

endmodule

// File: tb/tb_gps_uart_rx.sv
// tb/tb_gps_uart_rx.sv - directed bench for the GPS UART receiver and NMEA checksum
module tb_gps_uart_rx;

  localparam int CLK_HZ = 1536000;
  localparam int BAUD   = 9600;
  localparam int BIT    = 160;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gps_uart_rx_if bus ();

  gps_uart_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .OVERSAMPLE  (16),
    .VALID_TICKS (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int         n_valid = 0, n_ferr = 0, n_done = 0;
  int         vrun = 0, last_vw = 0, frun = 0, last_fw = 0;
  logic       prev_v = 1'b0;
  logic [7:0] q[$];

  always @(negedge clk) begin
    if (bus.valid && !prev_v) begin
      n_valid++;
      q.push_back(bus.data);
    end
    if (bus.valid) vrun++;
    else begin
      if (prev_v) last_vw = vrun;
      vrun = 0;
    end
    prev_v = bus.valid;
    if (bus.frame_err) begin
      n_ferr++;
      frun++;
    end else begin
      if (frun != 0) last_fw = frun;
      frun = 0;
    end
    if (bus.sentence_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      idle(BIT);
    end
    bus.rx = stop;
    idle(BIT);
    bus.rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  initial begin
    int         b_v, b_f, b_d;
    string      s;
    logic [7:0] r_byte;

    bus.rx = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    idle(4);
    chk("rst_data", bus.data, 8'h00);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_ferr", bus.frame_err, 1'b0);
    chk("rst_done", bus.sentence_done, 1'b0);
    chk("rst_ok", bus.checksum_ok, 1'b0);
    rst = 1'b0;
    idle(50);

    // single good byte
    b_v = n_valid; b_f = n_ferr; q.delete();
    send_byte(8'h24, 1'b1);
    idle(200);
    chk("t1_nvalid", n_valid - b_v, 1);
    chk("t1_byte", q[0], 8'h24);
    chk("t1_vwidth", last_vw, 80);
    chk("t1_ferr", n_ferr - b_f, 0);
    chk("t1_data", bus.data, 8'h24);

    // good sentence, back-to-back bytes
    s = "$GPRMC*4B";
    b_v = n_valid; b_d = n_done; q.delete();
    send_str(s);
    idle(200);
    chk("t2_nvalid", n_valid - b_v, 9);
    for (int i = 0; i < 9; i++) chk("t2_byte", q[i], s[i]);
    chk("t2_ndone", n_done - b_d, 1);
    chk("t2_ok", bus.checksum_ok, 1'b1);

    // wrong checksum, then lowercase hex
    b_d = n_done;
    send_str("$GPRMC*4C");
    idle(200);
    chk("t3_ndone_bad", n_done - b_d, 1);
    chk("t3_ok_bad", bus.checksum_ok, 1'b0);
    b_d = n_done;
    send_str("$GPRMC*4b");
    idle(200);
    chk("t3_ndone_lc", n_done - b_d, 1);
    chk("t3_ok_lc", bus.checksum_ok, 1'b1);

    // framing error mid-sentence
    b_v = n_valid; b_f = n_ferr; b_d = n_done;
    send_str("$GP");
    send_byte(8'h55, 1'b0);
    idle(200);
    chk("t4_nferr", n_ferr - b_f, 1);
    chk("t4_fwidth", last_fw, 1);
    chk("t4_nvalid", n_valid - b_v, 3);
    chk("t4_data_kept", bus.data, 8'h50);
    send_str("*4B");
    idle(200);
    chk("t4_ndone", n_done - b_d, 0);
    chk("t4_nvalid_tail", n_valid - b_v, 6);

    // short glitch, then a real byte
    b_v = n_valid; b_f = n_ferr; q.delete();
    bus.rx = 1'b0;
    idle(5);
    bus.rx = 1'b1;
    idle(300);
    chk("t5_glitch_valid", n_valid - b_v, 0);
    chk("t5_glitch_ferr", n_ferr - b_f, 0);
    send_byte(8'hA5, 1'b1);
    idle(200);
    chk("t5_nvalid", n_valid - b_v, 1);
    chk("t5_byte", q[0], 8'hA5);
    chk("t5_ferr", n_ferr - b_f, 0);

    // reset in bit 4 of a byte inside a sentence
    send_byte(8'h24, 1'b1);
    idle(20);
    chk("t6_pre_ok", bus.checksum_ok, 1'b1);
    r_byte = 8'h52;
    bus.rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      bus.rx = r_byte[i];
      idle(BIT);
    end
    bus.rx = r_byte[4];
    idle(80);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_data", bus.data, 8'h00);
    chk("t6_rst_valid", bus.valid, 1'b0);
    chk("t6_rst_ferr", bus.frame_err, 1'b0);
    chk("t6_rst_done", bus.sentence_done, 1'b0);
    chk("t6_rst_ok", bus.checksum_ok, 1'b0);
    bus.rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b_v = n_valid; b_d = n_done;
    idle(2000);
    chk("t6_quiet", n_valid - b_v, 0);
    send_str("$GPRMC*4B");
    idle(200);
    chk("t6_ndone", n_done - b_d, 1);
    chk("t6_ok", bus.checksum_ok, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
